// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive paths: FSM states, mode-register
// field positions, the baud-rate table and the divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Bit positions inside the 4-bit mode nibble
    localparam int unsigned MODE_BAUD_LSB = 0;
    localparam int unsigned MODE_PAR_EN   = 2;
    localparam int unsigned MODE_PAR_ODD  = 3;

    localparam int unsigned BAUD_SEL0 = 9600;
    localparam int unsigned BAUD_SEL1 = 115200;
    localparam int unsigned BAUD_SEL2 = 230400;
    localparam int unsigned BAUD_SEL3 = 921600;

    // Rounded clocks-per-bit for the selected baud rate
    function automatic logic [15:0] baud_div(input int unsigned clk_freq, input logic [1:0] sel);
        int unsigned baud;
        case (sel)
            2'd1:    baud = BAUD_SEL1;
            2'd2:    baud = BAUD_SEL2;
            2'd3:    baud = BAUD_SEL3;
            default: baud = BAUD_SEL0;
        endcase
        return 16'((clk_freq + baud / 2) / baud);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: loads DIV-1, counts down while running and flags bit_end at zero,
// reloading itself on every bit_end so consecutive bits stay exactly DIV clocks long.
module uart_baud_tick (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        load,
    input  logic [15:0] div,
    output logic        bit_end
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign bit_end = run && (cnt_q == 16'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (load || bit_end) begin
            cnt_d = div - 16'd1;
        end else if (run) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: pulls bytes from a show-ahead FIFO and sends start, 8 data bits LSB-first,
// optional parity and one stop bit. Baud and parity are frozen per frame at accept time.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 60000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic [3:0] mode,
    output logic       tx_line,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [15:0] DIV0 = baud_div(CLK_FREQ, 2'd0);
    localparam logic [15:0] DIV1 = baud_div(CLK_FREQ, 2'd1);
    localparam logic [15:0] DIV2 = baud_div(CLK_FREQ, 2'd2);
    localparam logic [15:0] DIV3 = baud_div(CLK_FREQ, 2'd3);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [15:0] div_q;
    logic        par_en_q;
    logic        par_bit_q;
    logic        tx_line_q, tx_d;

    logic        accept;
    logic        bit_end;
    logic [15:0] sel_div;
    logic [15:0] tick_div;

    assign data_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign accept     = data_valid && data_ready;
    assign tx_line    = tx_line_q;

    always_comb begin
        case (mode[MODE_BAUD_LSB +: 2])
            2'd1:    sel_div = DIV1;
            2'd2:    sel_div = DIV2;
            2'd3:    sel_div = DIV3;
            default: sel_div = DIV0;
        endcase
    end

    // A new frame starts its timer from the live mode; later bits reuse the latched divisor
    assign tick_div = accept ? sel_div : div_q;

    uart_baud_tick u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .run     (busy),
        .load    (accept),
        .div     (tick_div),
        .bit_end (bit_end)
    );

    // tx_d is the line level for the state being entered, so the line flop changes on the
    // same edge as the state and never passes through combinational logic to the pin.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_line_q;
        tx_done   = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (data_valid) begin
                    state_d   = START;
                    shift_d   = data_in;
                    bit_idx_d = 3'd0;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    tx_done = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_line_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_line_q <= tx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (accept) begin
            div_q     <= sel_div;
            par_en_q  <= mode[MODE_PAR_EN];
            par_bit_q <= (^data_in) ^ mode[MODE_PAR_ODD];
        end
    end

endmodule
